// File: rtl/apb_syscfg_ctrl.sv
// APB system-configuration slave: per-core boot vector, reset hold and self-timed reset pulse.
// Optional boot-register lock at 0xFF4 is enabled with `define SYSCFG_BOOT_LOCK_EN.
module apb_syscfg_ctrl #(
  parameter int unsigned        APB_ADDR_WIDTH = 12,
  parameter int unsigned        NUM_CC         = 2,
  // Matches the core-complex ITCM base address.
  parameter logic [31:0]        BOOT_RESET     = 32'h1000_0000,
  parameter logic [NUM_CC-1:0]  RST_INIT       = '0,
  parameter int unsigned        RST_PULSE_CYC  = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [32*NUM_CC-1:0]      cfg_cc_boot,
  output logic [NUM_CC-1:0]         cfg_cc_rst
);

  typedef enum logic [0:0] {StIdle, StPulse} st_e;

  localparam logic [31:0] IdVal = {8'h0, 8'(NUM_CC), 16'h0002};

  logic              acc, err, hi_zero, in_core, is_id, wr_ok, boot_lock;
  logic [7:0]        idx;
  logic [1:0]        off;
  logic [31:0]       rd_val;
  logic [NUM_CC-1:0] hold_v, busy_v;

`ifdef SYSCFG_BOOT_LOCK_EN
  logic is_lock, lock_q;

  assign is_lock = hi_zero && (PADDR[11:0] == 12'hFF4);

  // Sticky until PRESETn; writing 0 is ignored.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      lock_q <= 1'b0;
    end else if (wr_ok && is_lock && PWDATA[0]) begin
      lock_q <= 1'b1;
    end
  end

  assign boot_lock = lock_q;
`else
  assign boot_lock = 1'b0;
`endif

  always_comb begin
    acc     = PSEL & PENABLE;
    idx     = PADDR[11:4];
    off     = PADDR[3:2];
    hi_zero = ((PADDR >> 12) == '0);
    in_core = hi_zero && (idx < 8'(NUM_CC)) && (off != 2'd3);
    is_id   = hi_zero && (PADDR[11:0] == 12'hFF0);
    err     = 1'b1;
    rd_val  = '0;
    if (PADDR[1:0] != 2'b00) begin
      err = 1'b1;
    end else if (in_core) begin
      err = PWRITE && ((off == 2'd2) || ((off == 2'd0) && boot_lock));
      for (int unsigned i = 0; i < NUM_CC; i++) begin
        if (idx == 8'(i)) begin
          case (off)
            2'd0:    rd_val = cfg_cc_boot[32*i +: 32];
            2'd1:    rd_val = {31'b0, hold_v[i]};
            2'd2:    rd_val = {29'b0, hold_v[i], busy_v[i], cfg_cc_rst[i]};
            default: rd_val = '0;
          endcase
        end
      end
    end else if (is_id) begin
      err    = PWRITE;
      rd_val = IdVal;
`ifdef SYSCFG_BOOT_LOCK_EN
    end else if (is_lock) begin
      err    = 1'b0;
      rd_val = {31'b0, lock_q};
`endif
    end else begin
      err = 1'b1;
    end
  end

  assign wr_ok   = acc & PWRITE & ~err;
  assign PRDATA  = (acc & ~PWRITE & ~err) ? rd_val : '0;
  assign PREADY  = 1'b1;
  assign PSLVERR = acc & err;

  for (genvar g = 0; g < NUM_CC; g++) begin : g_cc
    st_e         st_q, st_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] boot_q, boot_d;
    logic        hold_q, hold_d, rst_q, busy, hit, trig;

    assign hit  = wr_ok & (idx == 8'(g));
    assign trig = hit & (off == 2'd1) & PWDATA[1];

    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        st_q   <= StIdle;
        cnt_q  <= '0;
        boot_q <= BOOT_RESET;
        hold_q <= RST_INIT[g];
        rst_q  <= RST_INIT[g];
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        boot_q <= boot_d;
        hold_q <= hold_d;
        // Registered OR keeps the core reset line glitch-free.
        rst_q  <= hold_d | (st_d == StPulse);
      end
    end

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      boot_d = (hit && (off == 2'd0)) ? PWDATA : boot_q;
      hold_d = (hit && (off == 2'd1)) ? PWDATA[0] : hold_q;
      case (st_q)
        StIdle: begin
          if (trig) begin
            st_d  = StPulse;
            cnt_d = 16'(RST_PULSE_CYC);
          end
        end
        StPulse: begin
          if (trig) begin
            cnt_d = 16'(RST_PULSE_CYC);
          end else if (cnt_q == 16'd1) begin
            st_d  = StIdle;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: st_d = StIdle;
      endcase
    end

    always_comb begin
      busy = (st_q == StPulse);
    end

    assign cfg_cc_boot[32*g +: 32] = boot_q;
    assign cfg_cc_rst[g]           = rst_q;
    assign hold_v[g]               = hold_q;
    assign busy_v[g]               = busy;
  end

endmodule

// File: tb/tb_apb_syscfg_ctrl.sv
// Scoreboard bench for apb_syscfg_ctrl: APB responses are queued at issue and checked by a monitor.
module tb_apb_syscfg_ctrl;

  localparam logic [31:0] BR = 32'h1000_0000;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [63:0] cfg_cc_boot;
  logic [1:0]  cfg_cc_rst;

  apb_syscfg_ctrl #(
    .APB_ADDR_WIDTH(12),
    .NUM_CC(2),
    .BOOT_RESET(BR),
    .RST_INIT(2'b00),
    .RST_PULSE_CYC(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .cfg_cc_boot(cfg_cc_boot), .cfg_cc_rst(cfg_cc_rst)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: every access phase is one APB response to compare against the queue.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer", 64'(PADDR), 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("prdata@%h", PADDR), 64'(PRDATA), 64'(e.rd));
        chk($sformatf("pslverr@%h", PADDR), 64'(PSLVERR), 64'(e.err));
        chk("pready", 64'(PREADY), 64'd1);
      end
    end
  end

  task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                     input logic [31:0] er, input logic ee);
    exp_t e;
    e.rd  = er;
    e.err = ee;
    exp_q.push_back(e);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic count_rst0(input string name, input int exp_n);
    int n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge PCLK);
      if (cfg_cc_rst[0]) n++;
      else break;
    end
    chk(name, 64'(n), 64'(exp_n));
  endtask

  initial begin
    int c0;
    PRESETn = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    repeat (3) @(posedge PCLK);
    #2;
    chk("rst_in_reset", 64'(cfg_cc_rst), 64'd0);
    chk("boot_in_reset", cfg_cc_boot, {BR, BR});
    PRESETn = 1'b1;

    // Reset state
    @(negedge PCLK);
    chk("rst_after_reset", 64'(cfg_cc_rst), 64'd0);
    chk("pslverr_idle", 64'(PSLVERR), 64'd0);
    chk("prdata_idle", 64'(PRDATA), 64'd0);
    chk("pready_idle", 64'(PREADY), 64'd1);
    apb(0, 12'h000, 0, BR, 0);
    apb(0, 12'h010, 0, BR, 0);
    apb(0, 12'hFF0, 0, 32'h0002_0002, 0);

    // Boot registers
    apb(1, 12'h010, 32'h8000_1000, 0, 0);
    apb(0, 12'h010, 0, 32'h8000_1000, 0);
    chk("boot1_out", 64'(cfg_cc_boot[63:32]), 64'h8000_1000);
    chk("boot0_untouched", 64'(cfg_cc_boot[31:0]), 64'(BR));
    apb(1, 12'h000, 32'h0000_4000, 0, 0);
    apb(0, 12'h000, 0, 32'h0000_4000, 0);
    chk("boot_both", cfg_cc_boot, {32'h8000_1000, 32'h0000_4000});

    // Reset pulse: exactly 16 cycles
    apb(1, 12'h004, 32'h2, 0, 0);
    count_rst0("pulse_len", 16);
    apb(0, 12'h008, 0, 32'h0, 0);

    // Retrigger at cycle 10 of the pulse
    apb(1, 12'h004, 32'h2, 0, 0);
    c0 = cyc;
    apb(0, 12'h008, 0, 32'h3, 0);
    apb(0, 12'h018, 0, 32'h0, 0);
    chk("core1_indep", 64'(cfg_cc_rst[1]), 64'd0);
    while (cyc < c0 + 7) begin
      @(posedge PCLK); #1;
    end
    chk("rst0_before_retrig", 64'(cfg_cc_rst[0]), 64'd1);
    apb(1, 12'h004, 32'h2, 0, 0);
    count_rst0("retrig_len", 16);
    apb(0, 12'h008, 0, 32'h0, 0);

    // HOLD combined with a pulse; PULSE bit reads back 0
    apb(1, 12'h004, 32'h3, 0, 0);
    apb(0, 12'h008, 0, 32'h7, 0);
    repeat (20) @(posedge PCLK);
    apb(0, 12'h008, 0, 32'h5, 0);
    apb(0, 12'h004, 0, 32'h1, 0);
    apb(1, 12'h004, 32'h0, 0, 0);
    apb(0, 12'h008, 0, 32'h0, 0);

    // HOLD on core 1
    apb(1, 12'h014, 32'h1, 0, 0);
    @(negedge PCLK);
    chk("hold1_rst", 64'(cfg_cc_rst), 64'b10);
    apb(0, 12'h018, 0, 32'h5, 0);
    apb(0, 12'h014, 0, 32'h1, 0);
    apb(1, 12'h014, 32'h0, 0, 0);
    @(negedge PCLK);
    chk("hold1_clear", 64'(cfg_cc_rst), 64'b00);

    // Error decode: no side effects, PRDATA 0
    apb(0, 12'h020, 0, 0, 1);
    apb(1, 12'h008, 32'hFFFF_FFFF, 0, 1);
    apb(0, 12'h008, 0, 32'h0, 0);
    apb(1, 12'h002, 32'hDEAD_BEEF, 0, 1);
    apb(0, 12'h000, 0, 32'h0000_4000, 0);
    apb(0, 12'h00C, 0, 0, 1);
    apb(0, 12'h001, 0, 0, 1);
    apb(1, 12'hFF0, 32'h1, 0, 1);
    apb(0, 12'hFF8, 0, 0, 1);
    apb(1, 12'h024, 32'h3, 0, 1);
    @(negedge PCLK);
    chk("err_no_rst", 64'(cfg_cc_rst), 64'd0);
    chk("err_no_boot", cfg_cc_boot, {32'h8000_1000, 32'h0000_4000});

`ifdef SYSCFG_BOOT_LOCK_EN
    apb(0, 12'hFF4, 0, 32'h0, 0);
    apb(1, 12'hFF4, 32'h1, 0, 0);
    apb(1, 12'hFF4, 32'h0, 0, 0);
    apb(0, 12'hFF4, 0, 32'h1, 0);
    apb(1, 12'h000, 32'h1234, 0, 1);
    apb(0, 12'h000, 0, 32'h0000_4000, 0);
    apb(1, 12'h014, 32'h1, 0, 0);
    apb(0, 12'h018, 0, 32'h5, 0);
    apb(1, 12'h014, 32'h0, 0, 0);
`else
    apb(0, 12'hFF4, 0, 0, 1);
    apb(1, 12'hFF4, 32'h1, 0, 1);
    apb(1, 12'h000, 32'h1234, 0, 0);
    apb(0, 12'h000, 0, 32'h1234, 0);
`endif

    // PRESETn mid-pulse aborts immediately
    apb(1, 12'h004, 32'h2, 0, 0);
    repeat (3) @(posedge PCLK);
    #3 PRESETn = 1'b0;
    #1;
    chk("rst_abort", 64'(cfg_cc_rst), 64'd0);
    chk("boot_abort", cfg_cc_boot, {BR, BR});
    @(posedge PCLK); #2;
    PRESETn = 1'b1;
    apb(0, 12'h008, 0, 32'h0, 0);
    apb(0, 12'h000, 0, BR, 0);
`ifdef SYSCFG_BOOT_LOCK_EN
    apb(0, 12'hFF4, 0, 32'h0, 0);
    apb(1, 12'h000, 32'h1234, 0, 0);
    apb(0, 12'h000, 0, 32'h1234, 0);
`endif

    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge PCLK);
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
